// File: rtl/router_addr_filter.sv
`default_nettype none
// ============================================================================
// router_addr_filter : multicasts address-windowed stream beats into per-lane
//                      FIFOs, then drains all lanes in lock-step on pop.
// Revision: 1.0
// ============================================================================
module router_addr_filter #(
  parameter int COUNT      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic                        i_reg_clear,
  input  logic [COUNT-1:0]            i_id,
  input  logic [ADDR_WIDTH-1:0]       i_start_addr,
  input  logic [ADDR_WIDTH-1:0]       i_end_addr,
  input  logic                        i_addr_write_en,
  input  logic                        i_route_en,
  input  logic                        i_data_valid,
  input  logic [ADDR_WIDTH-1:0]       i_data_addr,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_data_last,
  output logic                        o_data_ready,
  input  logic                        i_pop_en,
  output logic [COUNT*DATA_WIDTH-1:0] o_data,
  output logic [COUNT-1:0]            o_data_valid,
  output logic                        o_fifo_pop_ready,
  output logic                        o_fifo_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [COUNT-1:0] match, full, nonempty, push, pop;
  logic             accept, pop_act, blocked;
  logic             pop_ready;

  assign blocked      = |(match & full);
  assign o_data_ready = (state == FILL) && i_route_en && !blocked;
  assign accept       = i_data_valid && o_data_ready;
  assign pop_act      = i_pop_en && ((state == READY) || (state == DRAIN));
  assign o_fifo_empty = ~|nonempty;

  for (genvar k = 0; k < COUNT; k++) begin : g_lane
    localparam logic [COUNT-1:0] LANE_ID = COUNT'(k);

    logic [ADDR_WIDTH-1:0] win_start, win_end;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dvalid;
    logic                  win_wr;

    // An out-of-range i_id matches no LANE_ID, so such writes fall away.
    assign win_wr      = (state == IDLE) && i_addr_write_en && (i_id == LANE_ID);
    assign match[k]    = (win_start < win_end) && (i_data_addr >= win_start) &&
                         (i_data_addr < win_end);
    assign full[k]     = (cnt == CNT_W'(DEPTH));
    assign nonempty[k] = (cnt != '0);
    assign push[k]     = accept && match[k];
    assign pop[k]      = pop_act && nonempty[k];

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        win_start <= '0;
        win_end   <= '0;
      end else if (i_reg_clear) begin
        win_start <= '0;
        win_end   <= '0;
      end else if (win_wr) begin
        win_start <= i_start_addr;
        win_end   <= i_end_addr;
      end
    end

    always_ff @(posedge i_clk) begin
      if (push[k]) mem[wr_ptr] <= i_data;
    end

    // Push and pop live in disjoint states, so the count only moves one way.
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        dout   <= '0;
        dvalid <= 1'b0;
      end else if (i_reg_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        dout   <= '0;
        dvalid <= 1'b0;
      end else begin
        dvalid <= pop[k];
        if (push[k]) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          cnt    <= cnt + CNT_W'(1);
        end else if (pop[k]) begin
          dout   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PTR_W'(1);
          cnt    <= cnt - CNT_W'(1);
        end
      end
    end

    assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = dout;
    assign o_data_valid[k]                    = dvalid;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= IDLE;
      pop_ready <= 1'b0;
    end else if (i_reg_clear) begin
      state     <= IDLE;
      pop_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      pop_ready <= (state_nx == READY) || (state_nx == DRAIN);
    end
  end

  assign o_fifo_pop_ready = pop_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_route_en) state_nx = FILL;
      FILL:    if (accept && i_data_last) state_nx = READY;
      READY:   if (i_pop_en) state_nx = DRAIN;
      DRAIN:   if (!(|nonempty) && !(|pop)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_router_addr_filter.sv
`default_nettype none
// ============================================================================
// tb_router_addr_filter : directed stimulus with a pop scoreboard and monitor.
// Revision: 1.0
// ============================================================================
module tb_router_addr_filter;

  localparam int COUNT = 4;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic reg_clear = 1'b0;
  logic [COUNT-1:0] id = '0;
  logic [AW-1:0] start_addr = '0, end_addr = '0, data_addr = '0;
  logic addr_write_en = 1'b0, route_en = 1'b0, data_valid = 1'b0;
  logic data_last = 1'b0, pop_en = 1'b0;
  logic [DW-1:0] data = '0;
  logic data_ready, fifo_pop_ready, fifo_empty;
  logic [COUNT*DW-1:0] odata;
  logic [COUNT-1:0] odata_valid;

  router_addr_filter #(.COUNT(COUNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(reg_clear), .i_id(id),
    .i_start_addr(start_addr), .i_end_addr(end_addr), .i_addr_write_en(addr_write_en),
    .i_route_en(route_en), .i_data_valid(data_valid), .i_data_addr(data_addr),
    .i_data(data), .i_data_last(data_last), .o_data_ready(data_ready),
    .i_pop_en(pop_en), .o_data(odata), .o_data_valid(odata_valid),
    .o_fifo_pop_ready(fifo_pop_ready), .o_fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  due;
    logic [COUNT-1:0]    valid;
    logic [COUNT*DW-1:0] data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [DW-1:0] lane_q [COUNT][$];
  logic [DW-1:0] last_out [COUNT];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every scoreboard entry must appear exactly on its due cycle.
  always @(negedge clk) begin
    if (nrst) begin
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        mon_e = sbq.pop_front();
        chk("pop_valid", odata_valid, mon_e.valid);
        chk("pop_data", odata, mon_e.data);
      end else if (odata_valid != '0) begin
        chk("unexpected_valid", odata_valid, '0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int k = 0; k < COUNT; k++) begin
      lane_q[k].delete();
      last_out[k] = '0;
    end
  endtask

  task automatic win(input int lane, input int s, input int e);
    id = lane[COUNT-1:0];
    start_addr = s[AW-1:0];
    end_addr = e[AW-1:0];
    addr_write_en = 1'b1;
    tick();
    addr_write_en = 1'b0;
  endtask

  task automatic beat(input int a, input int d, input bit last, input bit exp_rdy,
                      input logic [COUNT-1:0] mask);
    data_valid = 1'b1;
    data_addr = a[AW-1:0];
    data = d[DW-1:0];
    data_last = last;
    #1 chk("data_ready", data_ready, exp_rdy);
    if (exp_rdy)
      for (int k = 0; k < COUNT; k++)
        if (mask[k]) lane_q[k].push_back(d[DW-1:0]);
    tick();
    data_valid = 1'b0;
    data_last = 1'b0;
  endtask

  task automatic pop(input bit active);
    exp_t e;
    e.due = cyc + 1;
    e.valid = '0;
    e.data = '0;
    pop_en = 1'b1;
    for (int k = 0; k < COUNT; k++) begin
      if (active && lane_q[k].size() > 0) begin
        e.valid[k] = 1'b1;
        last_out[k] = lane_q[k].pop_front();
      end
      e.data[k*DW +: DW] = last_out[k];
    end
    if (e.valid != '0) sbq.push_back(e);
    tick();
    pop_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    #2;
    chk("rst_ready", data_ready, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_pop_ready", fifo_pop_ready, 0);
    chk("rst_valid", odata_valid, 0);
    chk("rst_data", odata, 0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // Disjoint windows, one tile of 16 beats, four lock-step pops.
    for (int i = 0; i < 4; i++) win(i, 4*i, 4*i + 4);
    pop(0);
    route_en = 1'b1;
    #1 chk("idle_not_ready", data_ready, 0);
    tick();
    for (int i = 0; i < 16; i++) beat(i, i, i == 15, 1, COUNT'(1 << (i/4)));
    route_en = 1'b0;
    #1 chk("tileA_pop_ready", fifo_pop_ready, 1);
    chk("tileA_not_empty", fifo_empty, 0);
    for (int i = 0; i < 4; i++) pop(1);
    chk("tileA_drain_pop_ready", fifo_pop_ready, 1);
    tick(); tick();
    chk("tileA_empty", fifo_empty, 1);
    chk("tileA_idle", fifo_pop_ready, 0);

    // Overlap, inclusive/exclusive bounds, empty windows, unmatched drop, stall.
    win(0, 0, 8); win(1, 4, 12); win(2, 10, 3); win(3, 0, 0);
    route_en = 1'b1;
    tick();
    beat(4, 8'h44, 0, 1, 4'b0011);
    beat(8, 8'h88, 0, 1, 4'b0010);
    beat(20, 8'h14, 0, 1, 4'b0000);
    route_en = 1'b0;
    beat(4, 8'hEE, 1, 0, 4'b0000);
    route_en = 1'b1;
    beat(7, 8'h77, 0, 1, 4'b0011);
    beat(11, 8'h33, 1, 1, 4'b0010);
    route_en = 1'b0;
    for (int i = 0; i < 4; i++) pop(1);
    tick(); tick();
    chk("tileB_empty", fifo_empty, 1);

    // Ignored window writes, full-lane backpressure, clear while draining.
    win(5, 0, 16);
    win(0, 0, 16);
    route_en = 1'b1;
    tick();
    win(1, 100, 200);
    pop(0);
    for (int i = 0; i < 8; i++) beat(i, 8'h10 + i, 0, 1, (i < 4) ? 4'b0001 : 4'b0011);
    data_valid = 1'b1; data_addr = '0; data = 8'h99;
    for (int i = 0; i < 5; i++) begin
      #1 chk("full_stall_ready", data_ready, 0);
      tick();
    end
    data_valid = 1'b0;
    beat(150, 8'h96, 1, 1, 4'b0000);
    route_en = 1'b0;
    for (int i = 0; i < 6; i++) pop(1);
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
    model_clear();
    #1 chk("clr_empty", fifo_empty, 1);
    chk("clr_pop_ready", fifo_pop_ready, 0);
    chk("clr_valid", odata_valid, 0);
    chk("clr_data", odata, 0);
    route_en = 1'b1;
    tick();
    beat(0, 8'h5A, 1, 1, 4'b0000);
    route_en = 1'b0;
    #1 chk("clr_tile_pop_ready", fifo_pop_ready, 1);
    pop(1);
    tick(); tick();
    chk("clr_tile_idle", fifo_pop_ready, 0);

    // Asynchronous reset in the middle of a fill.
    win(0, 0, 16);
    route_en = 1'b1;
    tick();
    beat(1, 8'h21, 0, 1, 4'b0001);
    beat(2, 8'h22, 0, 1, 4'b0001);
    data_valid = 1'b1; data_addr = 8'd3; data = 8'h23;
    #1 chk("pre_rst_ready", data_ready, 1);
    chk("pre_rst_empty", fifo_empty, 0);
    #2 nrst = 1'b0;
    #1 chk("arst_ready", data_ready, 0);
    chk("arst_empty", fifo_empty, 1);
    chk("arst_pop_ready", fifo_pop_ready, 0);
    chk("arst_valid", odata_valid, 0);
    model_clear();
    @(negedge clk);
    nrst = 1'b1;
    data_valid = 1'b0;
    route_en = 1'b0;
    tick();
    chk("post_rst_empty", fifo_empty, 1);
    route_en = 1'b1;
    tick();
    beat(5, 8'h55, 1, 1, 4'b0000);
    route_en = 1'b0;
    pop(1);
    tick(); tick(); tick();
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
